// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the gshare branch predictor
package bp_pkg;

    typedef enum logic [0:0] {INIT, RUN} bp_state_t;

    localparam int DEF_IDX_W   = 8;
    localparam int DEF_ENTRIES = 1 << DEF_IDX_W;

    function automatic int entries(input int idx_w);
        return 1 << idx_w;
    endfunction

    // XOR of consecutive idx_w-bit slices of pc; result lives in the low idx_w bits
    function automatic logic [31:0] fold(input logic [31:0] pc, input int idx_w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i % idx_w] = r[i % idx_w] ^ pc[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] ctr, input int ctr_w);
        logic [31:0] top;
        top = (32'd1 << ctr_w) - 32'd1;
        return (ctr >= top) ? top : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// rtl/bp_pht.sv - pattern history table: counter array with lookup/update reads and one muxed write port
module bp_pht #(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic [CTR_W-1:0] init_data,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [CTR_W-1:0] upd_data,
    output logic [CTR_W-1:0] upd_ctr
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [CTR_W-1:0] mem [ENTRIES];

    // Reads see the array before this edge's write, giving read-before-write on collision
    assign rd_ctr  = mem[rd_idx];
    assign upd_ctr = mem[upd_idx];

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end else if (upd_we) begin
            mem[upd_idx] <= upd_data;
        end
    end

endmodule

// File: rtl/gshare_pred.sv
// rtl/gshare_pred.sv - gshare predictor top: init FSM, speculative GHR with repair, hashing, output registers
import bp_pkg::*;

module gshare_pred #(
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int GHR_W    = 8,
    parameter int INIT_CTR = 1 << (CTR_W - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_vld,
    input  logic [31:0]      lu_pc,
    output logic             pred_vld,
    output logic             pred_take,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_vld,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    output logic             busy
);

    localparam int ENTRIES = entries(IDX_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    bp_state_t        state;
    logic [IDX_W-1:0] ptr;
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] lu_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] lu_ctr;
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] upd_data;
    logic             lu_dir;
    logic             run;

    assign run     = (state == RUN);
    assign busy    = (state == INIT);
    assign lu_idx  = IDX_W'(fold(lu_pc, IDX_W)) ^ IDX_W'(ghr);
    assign upd_idx = IDX_W'(fold(upd_pc, IDX_W)) ^ IDX_W'(upd_ghr);
    assign lu_dir  = lu_ctr[CTR_W-1];

    assign upd_data = upd_taken ? CTR_W'(sat_inc(32'(upd_ctr), CTR_W))
                                : CTR_W'(sat_dec(32'(upd_ctr)));

    bp_pht #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht (
        .clk       (clk),
        .rd_idx    (lu_idx),
        .rd_ctr    (lu_ctr),
        .init_we   (busy && !rst),
        .init_idx  (ptr),
        .init_data (CTR_W'(INIT_CTR)),
        .upd_we    (run && upd_vld && !rst),
        .upd_idx   (upd_idx),
        .upd_data  (upd_data),
        .upd_ctr   (upd_ctr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            ptr       <= '0;
            ghr       <= '0;
            pred_vld  <= 1'b0;
            pred_take <= 1'b0;
            pred_ghr  <= '0;
        end else begin
            pred_vld <= 1'b0;
            case (state)
                INIT: begin
                    ghr <= '0;
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (lu_vld) begin
                        pred_vld  <= 1'b1;
                        pred_take <= lu_dir;
                        pred_ghr  <= ghr;
                    end
                    // A mispredict rebuilds history from the checkpoint, discarding this cycle's speculation
                    if (upd_vld && upd_mispred) begin
                        ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
                    end else if (lu_vld) begin
                        ghr <= {ghr[GHR_W-2:0], lu_dir};
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_pred.sv
// tb/tb_gshare_pred.sv - directed self-checking bench for gshare_pred
module tb_gshare_pred;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lu_vld = 1'b0;
    logic [31:0] lu_pc = '0;
    logic        pred_vld;
    logic        pred_take;
    logic [7:0]  pred_ghr;
    logic        upd_vld = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [7:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispred = 1'b0;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    gshare_pred dut (
        .clk         (clk),
        .rst         (rst),
        .lu_vld      (lu_vld),
        .lu_pc       (lu_pc),
        .pred_vld    (pred_vld),
        .pred_take   (pred_take),
        .pred_ghr    (pred_ghr),
        .upd_vld     (upd_vld),
        .upd_pc      (upd_pc),
        .upd_ghr     (upd_ghr),
        .upd_taken   (upd_taken),
        .upd_mispred (upd_mispred),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic t, input logic m);
        upd_vld = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t; upd_mispred = m;
        tick();
        upd_vld = 1'b0; upd_mispred = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic et, input logic [7:0] eg);
        lu_vld = 1'b1; lu_pc = pc;
        tick();
        lu_vld = 1'b0;
        chk({tag, ".vld"}, pred_vld, 1);
        chk({tag, ".take"}, pred_take, et);
        chk({tag, ".ghr"}, pred_ghr, eg);
    endtask

    // Repair with a zero checkpoint and not-taken: GHR becomes 0; touches only entry 0x02
    task automatic clear_ghr();
        upd(32'h200, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int          cnt;
        logic [7:0]  gm;

        // Init walk with lookups requested every cycle
        rst = 1'b1; lu_vld = 1'b1; lu_pc = 32'h1234;
        tick();
        chk("rst.vld", pred_vld, 0);
        chk("rst.take", pred_take, 0);
        chk("rst.ghr", pred_ghr, 0);
        chk("rst.busy", busy, 1);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("init.busy", busy, 1);
            chk("init.vld", pred_vld, 0);
            tick();
        end
        chk("init.done", busy, 0);
        chk("init.last_vld", pred_vld, 0);
        tick();
        lu_vld = 1'b0;
        chk("first.vld", pred_vld, 1);
        chk("first.take", pred_take, 1);
        chk("first.ghr", pred_ghr, 0);
        tick();
        chk("first.one_shot", pred_vld, 0);

        // Saturation on pc 0x100 (index 0x01 with GHR 0)
        clear_ghr();
        for (int i = 0; i < 4; i++) upd(32'h100, 8'h00, 1'b0, 1'b0);
        look("sat_nt4", 32'h100, 1'b0, 8'h00);
        upd(32'h100, 8'h00, 1'b0, 1'b0);
        look("sat_nt5", 32'h100, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) upd(32'h100, 8'h00, 1'b1, 1'b0);
        look("sat_t3", 32'h100, 1'b1, 8'h00);
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        upd(32'h100, 8'h00, 1'b0, 1'b0);
        clear_ghr();
        look("sat_top", 32'h100, 1'b1, 8'h00);

        // Speculative history: three back-to-back taken lookups
        clear_ghr();
        lu_vld = 1'b1; lu_pc = 32'h1000;
        tick();
        chk("spec0.take", pred_take, 1);
        chk("spec0.ghr", pred_ghr, 8'h00);
        tick();
        chk("spec1.take", pred_take, 1);
        chk("spec1.ghr", pred_ghr, 8'h01);
        tick();
        lu_vld = 1'b0;
        chk("spec2.vld", pred_vld, 1);
        chk("spec2.take", pred_take, 1);
        chk("spec2.ghr", pred_ghr, 8'h03);

        // Repair in the same cycle as a lookup; GHR is 0x07 here
        lu_vld = 1'b1; lu_pc = 32'h1000;
        upd_vld = 1'b1; upd_pc = 32'h3000; upd_ghr = 8'h05; upd_taken = 1'b0; upd_mispred = 1'b1;
        tick();
        lu_vld = 1'b0; upd_vld = 1'b0; upd_mispred = 1'b0;
        chk("rep.cur_ghr", pred_ghr, 8'h07);
        look("rep.next", 32'h1000, 1'b1, 8'h0A);

        // Collision: entry 0x01 holds 2, bring it to 1, then lookup + taken update together
        upd(32'h100, 8'h00, 1'b0, 1'b0);
        clear_ghr();
        lu_vld = 1'b1; lu_pc = 32'h100;
        upd_vld = 1'b1; upd_pc = 32'h100; upd_ghr = 8'h00; upd_taken = 1'b1; upd_mispred = 1'b0;
        tick();
        lu_vld = 1'b0; upd_vld = 1'b0;
        chk("coll.old", pred_take, 0);
        look("coll.new", 32'h100, 1'b1, 8'h00);

        // Reset in the middle of the walk restarts it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("mid.busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid.rst_busy", busy, 1);
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 600) begin
            cnt++;
            tick();
        end
        chk("mid.len", cnt, 256);

        // Walk every entry with a model of the speculative GHR
        gm = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ii;
            ii = 8'(i);
            look("reinit", {24'h0, ii ^ gm}, 1'b1, gm);
            gm = {gm[6:0], 1'b1};
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
